// File: rtl/gsm_burst_formatter_if.sv
// Signal bundle between the burst formatter, the GMSK modulator and the channel-coding stage.
// The formatter sits on the slave side; whoever drives requests and payload uses master.
interface gsm_burst_formatter_if;
    logic       next_symbol_kudasai;
    logic       bit_out;
    logic       burst_start;
    logic [2:0] tsc;
    logic [1:0] stealing;
    logic       data_bit;
    logic       data_valid;
    logic       data_ready;
    logic       burst_active;
    logic       burst_done;
    logic       underrun;

    modport master (
        output next_symbol_kudasai, burst_start, tsc, stealing, data_bit, data_valid,
        input  bit_out, data_ready, burst_active, burst_done, underrun
    );

    modport slave (
        input  next_symbol_kudasai, burst_start, tsc, stealing, data_bit, data_valid,
        output bit_out, data_ready, burst_active, burst_done, underrun
    );
endinterface

// File: rtl/gsm_burst_formatter.sv
// GSM normal-burst formatter: emits tail/payload/stealing/training/guard bits one per modulator request.
// Define GSM_DIFF_ENCODE_EN to add GSM 05.04 differential encoding on bit_out.
module gsm_burst_formatter #(
    parameter int unsigned GUARD_BITS = 8,
    parameter bit          IDLE_BIT   = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    gsm_burst_formatter_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        TAIL_H,
        DATA_A,
        STEAL_A,
        TRAIN,
        STEAL_B,
        DATA_B,
        TAIL_T,
        GUARD
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [5:0]  cnt;
    logic [5:0]  nxt_cnt;
    logic        req_d;
    logic        tick;
    logic        pending;
    logic [2:0]  tsc_q;
    logic [1:0]  steal_q;
    logic        bit_q;
    logic        ready_q;
    logic        active_q;
    logic        done_q;
    logic        underrun_q;
    logic        start_burst;
    logic        nxt_pre;
    logic        line_bit;
    logic        payload_bit;
    logic        is_data;
    logic [25:0] train_seq;
    logic [4:0]  train_idx;

    always_comb begin
        train_seq = 26'b00100101110000100010010111;
        case (tsc_q)
            3'd0: train_seq = 26'b00100101110000100010010111;
            3'd1: train_seq = 26'b00101101110111100010110111;
            3'd2: train_seq = 26'b01000011101110100100001110;
            3'd3: train_seq = 26'b01000111101101000100011110;
            3'd4: train_seq = 26'b00011010111001000001101011;
            3'd5: train_seq = 26'b01001110101100000100111010;
            3'd6: train_seq = 26'b10100111110110001010011111;
            3'd7: train_seq = 26'b11101111000100101110111100;
            default: train_seq = 26'b00100101110000100010010111;
        endcase
    end

    // state/cnt always describe the bit currently on bit_out; cnt counts that bit plus those still to come
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        start_burst = 1'b0;
        if (state == IDLE || (state == GUARD && cnt == 6'd1)) begin
            if (pending || bus.burst_start) begin
                start_burst = 1'b1;
                nxt_state   = TAIL_H;
                nxt_cnt     = 6'd3;
            end else begin
                nxt_state   = IDLE;
            end
        end else if (cnt == 6'd1) begin
            case (state)
                TAIL_H:  begin nxt_state = DATA_A;  nxt_cnt = 6'd57;             end
                DATA_A:  begin nxt_state = STEAL_A; nxt_cnt = 6'd1;              end
                STEAL_A: begin nxt_state = TRAIN;   nxt_cnt = 6'd26;             end
                TRAIN:   begin nxt_state = STEAL_B; nxt_cnt = 6'd1;              end
                STEAL_B: begin nxt_state = DATA_B;  nxt_cnt = 6'd57;             end
                DATA_B:  begin nxt_state = TAIL_T;  nxt_cnt = 6'd3;              end
                TAIL_T:  begin nxt_state = GUARD;   nxt_cnt = 6'(GUARD_BITS);    end
                default: begin nxt_state = IDLE;    nxt_cnt = 6'd1;              end
            endcase
        end else begin
            nxt_cnt = cnt - 6'd1;
        end
    end

    assign train_idx   = 5'(nxt_cnt - 6'd1);
    assign payload_bit = bus.data_valid & bus.data_bit;
    assign is_data     = (nxt_state == DATA_A) || (nxt_state == DATA_B);

    always_comb begin
        nxt_pre = 1'b0;
        case (nxt_state)
            IDLE:           nxt_pre = IDLE_BIT;
            STEAL_A:        nxt_pre = steal_q[0];
            STEAL_B:        nxt_pre = steal_q[1];
            TRAIN:          nxt_pre = train_seq[train_idx];
            DATA_A, DATA_B: nxt_pre = payload_bit;
            default:        nxt_pre = 1'b0;
        endcase
    end

`ifdef GSM_DIFF_ENCODE_EN
    logic diff_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            diff_prev <= 1'b1;
        end else if (tick) begin
            diff_prev <= nxt_pre;
        end
    end

    assign line_bit = nxt_pre ^ (start_burst | diff_prev);
`else
    assign line_bit = nxt_pre;
`endif

    // Ticks are at least two clocks apart, so state is stable on the edge that detects one;
    // that lets data_ready be registered and still land in the tick cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 6'd1;
            req_d      <= 1'b0;
            tick       <= 1'b0;
            pending    <= 1'b0;
            tsc_q      <= 3'd0;
            steal_q    <= 2'b00;
            bit_q      <= 1'b0;
            ready_q    <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            req_d   <= bus.next_symbol_kudasai;
            tick    <= bus.next_symbol_kudasai & ~req_d;
            ready_q <= bus.next_symbol_kudasai & ~req_d & is_data;
            done_q  <= 1'b0;
            if (bus.burst_start) begin
                pending <= 1'b1;
            end
            if (tick) begin
                state <= nxt_state;
                cnt   <= nxt_cnt;
                bit_q <= line_bit;
                if (start_burst) begin
                    pending    <= 1'b0;
                    tsc_q      <= bus.tsc;
                    steal_q    <= bus.stealing;
                    underrun_q <= 1'b0;
                    active_q   <= 1'b1;
                end else if (nxt_state == IDLE) begin
                    active_q   <= 1'b0;
                end
                if (is_data && !bus.data_valid) begin
                    underrun_q <= 1'b1;
                end
                if (nxt_state == GUARD && nxt_cnt == 6'd1) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.bit_out      = bit_q;
    assign bus.data_ready   = ready_q;
    assign bus.burst_active = active_q;
    assign bus.burst_done   = done_q;
    assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_gsm_burst_formatter.sv
// Self-checking bench for gsm_burst_formatter: random payloads and pacing checked against a burst-level model.
// Honours GSM_DIFF_ENCODE_EN so the same bench covers both builds.
module tb_gsm_burst_formatter;

    localparam int GUARD     = 8;
    localparam int BURST_LEN = 148 + GUARD;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    gsm_burst_formatter_if bus();

    gsm_burst_formatter #(
        .GUARD_BITS(GUARD),
        .IDLE_BIT  (1'b0)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          passed = 0;
    int          tick_period = 24;
    int          tick_hold   = 3;
    int          pidx;
    logic        model_prev = 1'b1;
    logic [25:0] tsc_tab [8];
    logic        pay [114];
    logic        pay_valid [114];
    logic        exp_q [$];

    function automatic logic encode(input logic d);
        logic o;
`ifdef GSM_DIFF_ENCODE_EN
        o = d ^ model_prev;
        model_prev = d;
`else
        o = d;
`endif
        return o;
    endfunction

    // Whole burst laid out field by field, then passed through the line encoder.
    task automatic build_expected(input logic [2:0] t, input logic [1:0] s);
        logic pre [$];
        for (int i = 0; i < 3; i++) pre.push_back(1'b0);
        for (int i = 0; i < 57; i++) pre.push_back(pay_valid[i] ? pay[i] : 1'b0);
        pre.push_back(s[0]);
        for (int i = 0; i < 26; i++) pre.push_back(tsc_tab[t][25 - i]);
        pre.push_back(s[1]);
        for (int i = 57; i < 114; i++) pre.push_back(pay_valid[i] ? pay[i] : 1'b0);
        for (int i = 0; i < 3 + GUARD; i++) pre.push_back(1'b0);
        model_prev = 1'b1;
        exp_q.delete();
        foreach (pre[i]) exp_q.push_back(encode(pre[i]));
    endtask

    task automatic make_payload(input bit all_ones, input int under_idx);
        for (int i = 0; i < 114; i++) begin
            pay[i]       = all_ones ? 1'b1 : 1'($urandom_range(0, 1));
            pay_valid[i] = (i != under_idx);
        end
    endtask

    task automatic drive_data();
        bus.data_valid = (pidx < 114) ? pay_valid[pidx] : 1'b1;
        bus.data_bit   = (pidx < 114) ? pay[pidx] : 1'b0;
    endtask

    // One modulator request: rise at a negedge, held tick_hold clocks, tick_period clocks in total.
    task automatic do_tick(output logic b, output logic rdy, output logic act,
                           output logic done, output logic und);
        b = 1'b0; rdy = 1'b0; act = 1'b0; done = 1'b0; und = 1'b0;
        bus.next_symbol_kudasai = 1'b1;
        for (int c = 1; c <= tick_period; c++) begin
            @(negedge clock);
            if (c == 1) begin
                rdy = bus.data_ready;
                bus.burst_start = 1'b0;
            end
            if (c == 2) begin
                b    = bus.bit_out;
                act  = bus.burst_active;
                done = bus.burst_done;
                und  = bus.underrun;
            end
            if (c == tick_hold) bus.next_symbol_kudasai = 1'b0;
        end
    endtask

    task automatic run_burst(input string name, input bit pulse_first, input bit all_ones,
                             input int under_idx, input int mid_at,
                             input logic [2:0] mid_tsc, input logic [1:0] mid_steal);
        logic b, rdy, act, done, und, und_first;
        int   mism = 0, first_bad = -1, rdy_cnt = 0, done_cnt = 0, done_at = -1, inactive = 0;
        logic got_bad = 1'b0, exp_bad = 1'b0;
        make_payload(all_ones, under_idx);
        if (pulse_first) begin
            bus.burst_start = 1'b1;
            @(negedge clock);
            bus.burst_start = 1'b0;
        end
        build_expected(bus.tsc, bus.stealing);
        pidx = 0;
        und_first = 1'b0;
        und = 1'b0;
        for (int k = 0; k < BURST_LEN; k++) begin
            drive_data();
            if (k == mid_at) begin
                bus.tsc         = mid_tsc;
                bus.stealing    = mid_steal;
                bus.burst_start = 1'b1;
            end
            do_tick(b, rdy, act, done, und);
            if (rdy) begin
                pidx++;
                rdy_cnt++;
            end
            if (b !== exp_q[k]) begin
                mism++;
                if (first_bad < 0) begin
                    first_bad = k; got_bad = b; exp_bad = exp_q[k];
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (act !== 1'b1) inactive++;
            if (k == 0) und_first = und;
        end
        checks++;
        if (mism != 0)
            $display("FAIL %s.bits: %0d wrong bits, first at %0d got %0b need %0b",
                     name, mism, first_bad, got_bad, exp_bad);
        else passed++;
        checks++;
        if (rdy_cnt != 114) $display("FAIL %s.ready_count: got %0d need 114", name, rdy_cnt);
        else passed++;
        checks++;
        if (done_cnt != 1 || done_at != BURST_LEN - 1)
            $display("FAIL %s.done: got %0d pulses last at %0d need 1 at %0d",
                     name, done_cnt, done_at, BURST_LEN - 1);
        else passed++;
        checks++;
        if (inactive != 0) $display("FAIL %s.active: %0d bits with burst_active low, need 0", name, inactive);
        else passed++;
        checks++;
        if (und_first !== 1'b0) $display("FAIL %s.underrun_clear: got %0b need 0", name, und_first);
        else passed++;
        checks++;
        if (und !== (under_idx >= 0 && under_idx < 114))
            $display("FAIL %s.underrun_final: got %0b need %0b", name, und, (under_idx >= 0 && under_idx < 114));
        else passed++;
    endtask

    task automatic check_idle(input string name, input int n, input logic exp_und);
        logic b, rdy, act, done, und, e;
        int   bad_bits = 0, bad_stat = 0;
        for (int k = 0; k < n; k++) begin
            bus.data_valid = 1'b1;
            bus.data_bit   = 1'($urandom_range(0, 1));
            do_tick(b, rdy, act, done, und);
            e = encode(1'b0);
            if (b !== e) bad_bits++;
            if (rdy !== 1'b0 || act !== 1'b0 || done !== 1'b0 || und !== exp_und) bad_stat++;
        end
        checks++;
        if (bad_bits != 0) $display("FAIL %s.idle_bits: %0d wrong idle bits, need 0", name, bad_bits);
        else passed++;
        checks++;
        if (bad_stat != 0) $display("FAIL %s.idle_status: %0d ticks with wrong status, need 0", name, bad_stat);
        else passed++;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        outs = {bus.bit_out, bus.data_ready, bus.burst_active, bus.burst_done, bus.underrun};
        checks++;
        if (outs !== 5'b0) $display("FAIL reset.outputs: got %b need 00000", outs);
        else passed++;
        reset_n = 1'b1;
        model_prev = 1'b1;
        @(negedge clock);
        tick_period = 8; tick_hold = 2;
        check_idle("reset", 4, 1'b0);
    endtask

    task automatic test_single_burst();
        tick_period = 24; tick_hold = 3;
        bus.tsc = 3'd0; bus.stealing = 2'b00;
        run_burst("single", 1'b1, 1'b1, -1, -1, 3'd0, 2'b00);
        check_idle("single", 3, 1'b0);
    endtask

    task automatic test_random_bursts();
        for (int t = 0; t < 8; t++) begin
            tick_period = $urandom_range(4, 10);
            tick_hold   = $urandom_range(1, tick_period - 1);
            bus.tsc      = 3'(t);
            bus.stealing = 2'($urandom_range(0, 3));
            run_burst($sformatf("random_tsc%0d", t), 1'b1, 1'b0, -1, -1, 3'd0, 2'b00);
            check_idle($sformatf("random_tsc%0d", t), 2, 1'b0);
        end
    endtask

    task automatic test_underrun();
        tick_period = 10; tick_hold = 2;
        bus.tsc = 3'($urandom_range(0, 7)); bus.stealing = 2'($urandom_range(0, 3));
        run_burst("underrun", 1'b1, 1'b0, 9, -1, 3'd0, 2'b00);
        check_idle("underrun_sticky", 3, 1'b1);
        run_burst("after_underrun", 1'b1, 1'b0, -1, -1, 3'd0, 2'b00);
        check_idle("after_underrun", 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        tick_period = 6; tick_hold = 2;
        bus.tsc = 3'd2; bus.stealing = 2'b11;
        run_burst("b2b_first", 1'b1, 1'b0, -1, 100, 3'd5, 2'b10);
        run_burst("b2b_second", 1'b0, 1'b0, -1, -1, 3'd0, 2'b00);
        check_idle("b2b", 3, 1'b0);
    endtask

    task automatic test_held_request();
        tick_period = 14; tick_hold = 10;
        bus.tsc = 3'($urandom_range(0, 7)); bus.stealing = 2'($urandom_range(0, 3));
        run_burst("held_request", 1'b1, 1'b0, -1, -1, 3'd0, 2'b00);
        check_idle("held_request", 3, 1'b0);
    endtask

    task automatic test_reset_mid_train();
        logic b, rdy, act, done, und;
        logic [4:0] outs;
        tick_period = 6; tick_hold = 2;
        bus.tsc = 3'd6; bus.stealing = 2'b01;
        make_payload(1'b0, -1);
        bus.burst_start = 1'b1;
        @(negedge clock);
        bus.burst_start = 1'b0;
        pidx = 0;
        for (int k = 0; k < 70; k++) begin
            drive_data();
            do_tick(b, rdy, act, done, und);
            if (rdy) pidx++;
        end
        checks++;
        if (act !== 1'b1) $display("FAIL mid_train.active_before: got %0b need 1", act);
        else passed++;
        reset_n = 1'b0;
        #1;
        outs = {bus.bit_out, bus.data_ready, bus.burst_active, bus.burst_done, bus.underrun};
        checks++;
        if (outs !== 5'b0) $display("FAIL mid_train.outputs: got %b need 00000", outs);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        model_prev = 1'b1;
        @(negedge clock);
        check_idle("mid_train", 5, 1'b0);
        run_burst("after_reset", 1'b1, 1'b0, -1, -1, 3'd0, 2'b00);
    endtask

    initial begin
        tsc_tab[0] = 26'b00100101110000100010010111;
        tsc_tab[1] = 26'b00101101110111100010110111;
        tsc_tab[2] = 26'b01000011101110100100001110;
        tsc_tab[3] = 26'b01000111101101000100011110;
        tsc_tab[4] = 26'b00011010111001000001101011;
        tsc_tab[5] = 26'b01001110101100000100111010;
        tsc_tab[6] = 26'b10100111110110001010011111;
        tsc_tab[7] = 26'b11101111000100101110111100;
        bus.next_symbol_kudasai = 1'b0;
        bus.burst_start         = 1'b0;
        bus.tsc                 = 3'd0;
        bus.stealing            = 2'b00;
        bus.data_bit            = 1'b0;
        bus.data_valid          = 1'b0;
        $display("[TB] gsm_burst_formatter bench start");
        test_reset();
        test_single_burst();
        test_random_bursts();
        test_underrun();
        test_back_to_back();
        test_held_request();
        test_reset_mid_train();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
